// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions, datapath defaults and
// small helpers used by the writeback stage and its register file.
package alu_pkg;

   localparam int ALU_DATA_W  = 8;
   localparam int ALU_FLAGS_W = 8;

   typedef enum logic [3:0] {
      ALU_OP_ADD = 4'h0,
      ALU_OP_SUB = 4'h1,
      ALU_OP_AND = 4'h4,
      ALU_OP_OR  = 4'h5,
      ALU_OP_XOR = 4'h6
   } alu_op_e;

   // Bits 7..4 of the flags byte are reserved.
   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   function automatic logic [ALU_FLAGS_W-1:0] merge_flags(
      input logic [ALU_FLAGS_W-1:0] cur,
      input logic [ALU_FLAGS_W-1:0] nxt,
      input logic [ALU_FLAGS_W-1:0] mask
   );
      return (cur & ~mask) | (nxt & mask);
   endfunction

   // True for an address that names a real, writable register (not R0).
   function automatic logic addr_live(
      input int unsigned addr,
      input int unsigned num_regs
   );
      return (addr != 0) && (addr < num_regs);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: one write port, two combinational read ports.
// R0 and out-of-range addresses always read as zero and are never written.
module alu_regfile
   import alu_pkg::*;
#(
   parameter int          DATA_W   = ALU_DATA_W,
   parameter int unsigned NUM_REGS = 8,
   parameter int          AW       = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [AW-1:0]     raddr2,
   output logic [DATA_W-1:0] rdata2
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && addr_live(32'(waddr), NUM_REGS)) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = '0;
      if (addr_live(32'(raddr1), NUM_REGS)) begin
         rdata1 = regs[raddr1];
      end
   end

   always_comb begin
      rdata2 = '0;
      if (addr_live(32'(raddr2), NUM_REGS)) begin
         rdata2 = regs[raddr2];
      end
   end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage behind the 8-bit ALU: one-deep stage register, commit to the
// register file and masked flags. ALU_WB_FORWARD_EN adds stage-to-read bypass.
module alu_writeback
   import alu_pkg::*;
#(
   parameter  int          DATA_W   = ALU_DATA_W,
   parameter  int unsigned NUM_REGS = 8,
   localparam int          AW       = $clog2(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_result,
   input  logic [ALU_FLAGS_W-1:0] in_flags,
   input  logic [ALU_FLAGS_W-1:0] in_flags_mask,
   input  logic [AW-1:0]          in_rd,
   input  logic                   in_rd_we,
   input  logic                   hold,
   input  logic [AW-1:0]          rs1_addr,
   input  logic [AW-1:0]          rs2_addr,
   output logic [DATA_W-1:0]      rs1_data,
   output logic [DATA_W-1:0]      rs2_data,
   output logic [ALU_FLAGS_W-1:0] flags_q,
   output logic [15:0]            commit_count
);

   logic                   st_valid;
   logic [DATA_W-1:0]      st_result;
   logic [ALU_FLAGS_W-1:0] st_flags;
   logic [ALU_FLAGS_W-1:0] st_mask;
   logic [AW-1:0]          st_rd;
   logic                   st_we;

   logic                   accept;
   logic                   commit;
   logic [DATA_W-1:0]      rf_rs1;
   logic [DATA_W-1:0]      rf_rs2;

   assign in_ready = !rst && (!st_valid || !hold);
   assign accept   = in_valid && in_ready;
   assign commit   = st_valid && !hold;

   // Stage boundary: ALU output captured into the stage register.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_valid <= 1'b0;
      end else if (accept) begin
         st_valid <= 1'b1;
      end else if (commit) begin
         st_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         st_result <= in_result;
         st_flags  <= in_flags;
         st_mask   <= in_flags_mask;
         st_rd     <= in_rd;
         st_we     <= in_rd_we;
      end
   end

   // Stage boundary: commit into architectural flags and the commit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q      <= '0;
         commit_count <= '0;
      end else if (commit) begin
         flags_q      <= merge_flags(flags_q, st_flags, st_mask);
         commit_count <= commit_count + 16'd1;
      end
   end

   alu_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we     (commit && st_we),
      .waddr  (st_rd),
      .wdata  (st_result),
      .raddr1 (rs1_addr),
      .rdata1 (rf_rs1),
      .raddr2 (rs2_addr),
      .rdata2 (rf_rs2)
   );

`ifdef ALU_WB_FORWARD_EN
   logic fwd_rs1;
   logic fwd_rs2;

   // A pending write wins over the committed copy; R0 and out-of-range stay 0.
   always_comb begin
      fwd_rs1 = st_valid && st_we && (st_rd == rs1_addr) &&
                addr_live(32'(rs1_addr), NUM_REGS);
      fwd_rs2 = st_valid && st_we && (st_rd == rs2_addr) &&
                addr_live(32'(rs2_addr), NUM_REGS);
   end

   assign rs1_data = fwd_rs1 ? st_result : rf_rs1;
   assign rs2_data = fwd_rs2 ? st_result : rf_rs2;
`else
   assign rs1_data = rf_rs1;
   assign rs2_data = rf_rs2;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: stimulus pushes expected commits built
// from an architectural model; a monitor pops one per observed commit.
module tb_alu_writeback;

   localparam int DATA_W   = 8;
   localparam int NUM_REGS = 8;
   localparam int AW       = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic [7:0]        in_flags;
   logic [7:0]        in_flags_mask;
   logic [AW-1:0]     in_rd;
   logic              in_rd_we;
   logic              hold;
   logic [AW-1:0]     rs1_addr;
   logic [AW-1:0]     rs2_addr;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic [7:0]        flags_q;
   logic [15:0]       commit_count;

   always #5 clk = ~clk;

   alu_writeback #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_result     (in_result),
      .in_flags      (in_flags),
      .in_flags_mask (in_flags_mask),
      .in_rd         (in_rd),
      .in_rd_we      (in_rd_we),
      .hold          (hold),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .flags_q       (flags_q),
      .commit_count  (commit_count)
   );

   typedef struct {
      logic [AW-1:0]     rd;
      logic              we;
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] reg_val;
      logic [7:0]        flags;
      logic [15:0]       cnt;
   } exp_t;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] mdl_regs [NUM_REGS];
   logic [7:0]        mdl_flags;
   logic [15:0]       mdl_cnt;
   int                n_checks = 0;
   int                n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) mdl_regs[i] = '0;
      mdl_flags = '0;
      mdl_cnt   = '0;
      exp_q.delete();
   endtask

   // Architectural effect of one accepted entry once it has committed.
   task automatic push_expected(input logic [DATA_W-1:0] res, input logic [7:0] fl,
                                input logic [7:0] mk, input logic [AW-1:0] rd, input logic we);
      exp_t e;
      mdl_flags = (mdl_flags & ~mk) | (fl & mk);
      mdl_cnt   = mdl_cnt + 16'd1;
      if (we && rd != 0) mdl_regs[rd] = res;
      e.rd      = rd;
      e.we      = we;
      e.result  = res;
      e.reg_val = (rd == 0) ? '0 : mdl_regs[rd];
      e.flags   = mdl_flags;
      e.cnt     = mdl_cnt;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic v, input logic [DATA_W-1:0] res, input logic [7:0] fl,
                       input logic [7:0] mk, input logic [AW-1:0] rd, input logic we,
                       input logic hd);
      @(negedge clk);
      #1;
      in_valid      = v;
      in_result     = res;
      in_flags      = fl;
      in_flags_mask = mk;
      in_rd         = rd;
      in_rd_we      = we;
      hold          = hd;
      #1;
      if (v && in_ready) push_expected(res, fl, mk, rd, we);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic step_rand(input logic hd);
      step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, NUM_REGS - 1)), 1'($urandom_range(0, 1)), hd);
   endtask

   task automatic drain();
      @(negedge clk);
      #1;
      hold = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
         #3;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every change of commit_count is one commit to be matched.
   initial begin : monitor
      exp_t              e;
      logic [DATA_W-1:0] exp_rd;
      logic [15:0]       last_cnt;
      logic [7:0]        cur_flags;
      last_cnt  = '0;
      cur_flags = '0;
      rs2_addr  = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            last_cnt  = '0;
            cur_flags = '0;
         end else if (commit_count !== last_cnt) begin
            last_cnt = commit_count;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL spurious_commit: count 0x%0h with nothing pending", commit_count);
            end else begin
               e      = exp_q.pop_front();
               exp_rd = e.reg_val;
`ifdef ALU_WB_FORWARD_EN
               if (exp_q.size() != 0 && exp_q[0].we && exp_q[0].rd == e.rd && e.rd != 0)
                  exp_rd = exp_q[0].result;
`endif
               cur_flags = e.flags;
               rs2_addr  = e.rd;
               #1;
               chk("commit_reg", 32'(rs2_data), 32'(exp_rd));
               chk("commit_flags", 32'(flags_q), 32'(e.flags));
               chk("commit_count", 32'(commit_count), 32'(e.cnt));
            end
         end else begin
            chk("idle_flags", 32'(flags_q), 32'(cur_flags));
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "simulation timeout");
   end

   initial begin : stimulus
      logic [DATA_W-1:0] old3;
      logic [15:0]       cnt0;
      logic [DATA_W-1:0] exp_fwd;

      rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_flags_mask = '0;
      in_rd = '0; in_rd_we = 1'b0; hold = 1'b0; rs1_addr = '0;
      model_reset();

      repeat (2) @(negedge clk);
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_flags", 32'(flags_q), 32'h00);
      chk("reset_count", 32'(commit_count), 32'h0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 32'(in_ready), 32'd1);

      // Basic commit plus read in the cycle after accept.
      step(1'b1, 8'h34, 8'h02, 8'hFF, 3'd2, 1'b1, 1'b0);
      rs1_addr = 3'd2;
      #1;
`ifdef ALU_WB_FORWARD_EN
      exp_fwd = 8'h34;
`else
      exp_fwd = 8'h00;
`endif
      chk("read_before_commit", 32'(rs1_data), 32'(exp_fwd));
      @(posedge clk);
      #1;
      chk("r2_after_commit", 32'(rs1_data), 32'h34);
      chk("flags_after_commit", 32'(flags_q), 32'h02);
      chk("count_after_commit", 32'(commit_count), 32'd1);

      // Masked flag update.
      step(1'b1, 8'h00, 8'h0F, 8'hFF, 3'd1, 1'b0, 1'b0);
      step(1'b1, 8'h00, 8'hF0, 8'h30, 3'd1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("masked_flags", 32'(flags_q), 32'h3F);

      // Hold keeps a pending entry; a new offer during hold is refused.
      old3 = mdl_regs[3];
      cnt0 = mdl_cnt;
      step(1'b1, 8'h5A, 8'h04, 8'h0F, 3'd3, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         in_valid = 1'b1; in_result = 8'hEE; in_rd = 3'd4; in_rd_we = 1'b1;
         rs1_addr = 3'd3;
         #1;
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_count", 32'(commit_count), 32'(cnt0));
`ifdef ALU_WB_FORWARD_EN
         chk("hold_read", 32'(rs1_data), 32'h5A);
`else
         chk("hold_read", 32'(rs1_data), 32'(old3));
`endif
      end
      step(1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
      rs1_addr = 3'd3;
      #1;
      chk("release_count", 32'(commit_count), 32'(cnt0 + 16'd1));
      chk("release_r3", 32'(rs1_data), 32'h5A);

      // Back-to-back accepts, one commit per cycle.
      cnt0 = mdl_cnt;
      for (int i = 0; i < 4; i++)
         step(1'b1, 8'(8'h10 + i), 8'h00, 8'h00, 3'(4 + i), 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("b2b_count", 32'(commit_count), 32'(cnt0 + 16'd4));

      // R0 write: value dropped, flags and count still update.
      step(1'b1, 8'hAA, 8'h81, 8'hFF, 3'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      rs1_addr = 3'd0;
      #1;
      chk("r0_read", 32'(rs1_data), 32'h00);
      chk("r0_flags", 32'(flags_q), 32'h81);
      chk("r0_count", 32'(commit_count), 32'(mdl_cnt));

      // Randomized traffic with random hold.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0)
            step(1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'($urandom_range(0, 1)));
         else
            step_rand(1'($urandom_range(0, 3) == 0));
      end
      drain();

      // Reset while an entry is pending.
      step(1'b1, 8'h77, 8'h08, 8'hFF, 3'd5, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      in_valid = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      chk("midreset_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      for (int r = 0; r < NUM_REGS; r++) begin
         rs1_addr = 3'(r);
         #1;
         chk("midreset_reg", 32'(rs1_data), 32'h00);
      end
      chk("midreset_flags", 32'(flags_q), 32'h00);
      chk("midreset_count", 32'(commit_count), 32'h0);
      chk("midreset_in_ready2", 32'(in_ready), 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b0; hold = 1'b0; in_valid = 1'b0;
      #1;
      chk("ready_after_midreset", 32'(in_ready), 32'd1);

      // Counter wrap: 0xFFFF commits, then one more.
      for (int i = 0; i < 65535; i++) step_rand(1'b0);
      drain();
      chk("count_ffff", 32'(commit_count), 32'hFFFF);
      step_rand(1'b0);
      drain();
      chk("count_wrap", 32'(commit_count), 32'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
